// File: rtl/agc_pkg.sv
// -----------------------------------------------------------------------------
// agc_pkg
// Shared definitions for the AGC gain-control PWM modulator slice.
//   PWM_W        : default duty / phase counter width
//   DIV_W        : default prescaler width
//   pwm_mode_e   : modulation scheme (PWM_MODE_CNT = counter, PWM_MODE_SD = sigma-delta)
// -----------------------------------------------------------------------------
package agc_pkg;

   localparam int PWM_W = 8;
   localparam int DIV_W = 4;

   typedef enum logic {
      PWM_MODE_CNT = 1'b0,
      PWM_MODE_SD  = 1'b1
   } pwm_mode_e;

endpackage : agc_pkg

// File: rtl/agc_pwm_presc.sv
// -----------------------------------------------------------------------------
// agc_pwm_presc
// Clock prescaler for the AGC modulator. It produces a one-cycle tick every
// div+1 clk cycles. clr holds the counter at 0 and suppresses the tick, so the
// first tick after clr drops arrives div+1 cycles later.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : hold counter at zero, no tick
//   div          : divide value; the tick fires when the count equals div
//   tick         : one-cycle pulse (combinational from the count)
// -----------------------------------------------------------------------------
module agc_pwm_presc #(
   parameter int DIV_W = agc_pkg::DIV_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      tick      = 1'b0;
      div_cnt_d = div_cnt_q;
      if (clr) begin
         div_cnt_d = '0;
      end else if (div_cnt_q == div) begin
         tick      = 1'b1;
         div_cnt_d = '0;
      end else if (div_cnt_q > div) begin
         // div was lowered below the running count: restart quietly.
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule : agc_pwm_presc

// File: rtl/agc_pwm_mod.sv
// -----------------------------------------------------------------------------
// agc_pwm_mod
// Gain-control modulator driving the RF AGC filter pin. It runs either a plain
// counter PWM or a first-order sigma-delta at the prescaled tick rate.
// New duty values are double-buffered and take effect only at a period boundary.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   pwm_ena         : modulator enable (0 = idle, output parked at pwm_inv)
//   pwm_inv         : output polarity invert, applied on the next clk
//   pwm_mode        : 0 counter PWM, 1 sigma-delta; sampled at a boundary
//   pwm_div         : tick every pwm_div+1 clk cycles
//   pwm_val         : requested duty
//   pwm_val_up      : one-cycle strobe qualifying pwm_val
//   pwm_out         : registered modulated output
//   pwm_period_end  : one-cycle pulse after each 2^PWM_W-tick period
//   duty_cur        : duty currently being modulated
// -----------------------------------------------------------------------------
module agc_pwm_mod
   import agc_pkg::pwm_mode_e, agc_pkg::PWM_MODE_CNT, agc_pkg::PWM_MODE_SD;
#(
   parameter int PWM_W = agc_pkg::PWM_W,
   parameter int DIV_W = agc_pkg::DIV_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pwm_ena,
   input  logic             pwm_inv,
   input  logic             pwm_mode,
   input  logic [DIV_W-1:0] pwm_div,
   input  logic [PWM_W-1:0] pwm_val,
   input  logic             pwm_val_up,
   output logic             pwm_out,
   output logic             pwm_period_end,
   output logic [PWM_W-1:0] duty_cur
);

   localparam logic [PWM_W-1:0] PHASE_MAX = '1;

   logic             tick;
   logic             boundary;
   logic             raw;
   pwm_mode_e        mode_in;

   logic [PWM_W-1:0] phase_cnt_q, phase_cnt_d;
   logic [PWM_W:0]   acc_q,       acc_d;
   logic [PWM_W-1:0] shadow_q,    shadow_d;
   logic             pending_q,   pending_d;
   logic [PWM_W-1:0] duty_cur_q,  duty_cur_d;
   pwm_mode_e        mode_act_q,  mode_act_d;
   logic             pwm_out_q,   pwm_out_d;
   logic             period_end_q, period_end_d;

   // The tick is suppressed while disabled, so every tick-derived event below is
   // implicitly qualified by pwm_ena.
   agc_pwm_presc #(
      .DIV_W (DIV_W)
   ) u_presc (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (~pwm_ena),
      .div     (pwm_div),
      .tick    (tick)
   );

   always_comb begin
      mode_in      = pwm_mode_e'(pwm_mode);
      boundary     = tick && (phase_cnt_q == PHASE_MAX);

      // Both sources are pure state, so raw is stable between ticks.
      raw          = (mode_act_q == PWM_MODE_SD) ? acc_q[PWM_W]
                                                 : (phase_cnt_q < duty_cur_q);

      phase_cnt_d  = phase_cnt_q;
      acc_d        = acc_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      duty_cur_d   = duty_cur_q;
      mode_act_d   = mode_act_q;
      pwm_out_d    = raw ^ pwm_inv;
      period_end_d = boundary;

      if (pwm_val_up) begin
         shadow_d  = pwm_val;
         pending_d = 1'b1;
      end

      if (!pwm_ena) begin
         phase_cnt_d = '0;
         acc_d       = '0;
         pending_d   = 1'b0;
         duty_cur_d  = pwm_val;
         mode_act_d  = mode_in;
         pwm_out_d   = pwm_inv;
      end else if (tick) begin
         phase_cnt_d = phase_cnt_q + PWM_W'(1);
         if (mode_act_q == PWM_MODE_SD) begin
            // Carry out of the low PWM_W bits is the sigma-delta output bit.
            acc_d = {1'b0, acc_q[PWM_W-1:0]} + {1'b0, duty_cur_q};
         end
         if (boundary) begin
            mode_act_d = mode_in;
            if ((mode_in == PWM_MODE_SD) && (mode_act_q == PWM_MODE_CNT)) begin
               acc_d = '0;
            end
            // A strobe landing on the boundary is newer than the shadow copy.
            if (pwm_val_up) begin
               duty_cur_d = pwm_val;
               pending_d  = 1'b0;
            end else if (pending_q) begin
               duty_cur_d = shadow_q;
               pending_d  = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_cnt_q  <= '0;
         acc_q        <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         duty_cur_q   <= '0;
         mode_act_q   <= PWM_MODE_CNT;
         pwm_out_q    <= 1'b0;
         period_end_q <= 1'b0;
      end else begin
         phase_cnt_q  <= phase_cnt_d;
         acc_q        <= acc_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         duty_cur_q   <= duty_cur_d;
         mode_act_q   <= mode_act_d;
         pwm_out_q    <= pwm_out_d;
         period_end_q <= period_end_d;
      end
   end

   assign pwm_out        = pwm_out_q;
   assign pwm_period_end = period_end_q;
   assign duty_cur       = duty_cur_q;

endmodule : agc_pwm_mod

// File: tb/tb_agc_pwm_mod.sv
// -----------------------------------------------------------------------------
// tb_agc_pwm_mod
// Self-checking bench for agc_pwm_mod. Each scenario task pushes the expected
// per-period result (high cycles, period length, rising edges, duty) to a
// scoreboard queue. measure_period pops the entry and compares it with what the
// DUT produced over one full period. Inputs are driven and outputs sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_agc_pwm_mod;

   localparam int PWM_W = 8;
   localparam int DIV_W = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             pwm_ena;
   logic             pwm_inv;
   logic             pwm_mode;
   logic [DIV_W-1:0] pwm_div;
   logic [PWM_W-1:0] pwm_val;
   logic             pwm_val_up;
   logic             pwm_out;
   logic             pwm_period_end;
   logic [PWM_W-1:0] duty_cur;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string tag;
      int    highs;
      int    len;
      int    rises;
      int    duty;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   agc_pwm_mod #(
      .PWM_W (PWM_W),
      .DIV_W (DIV_W)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .pwm_ena        (pwm_ena),
      .pwm_inv        (pwm_inv),
      .pwm_mode       (pwm_mode),
      .pwm_div        (pwm_div),
      .pwm_val        (pwm_val),
      .pwm_val_up     (pwm_val_up),
      .pwm_out        (pwm_out),
      .pwm_period_end (pwm_period_end),
      .duty_cur       (duty_cur)
   );

   task automatic strobe(input logic [PWM_W-1:0] v);
      @(negedge clk);
      pwm_val    = v;
      pwm_val_up = 1'b1;
      @(negedge clk);
      pwm_val_up = 1'b0;
   endtask

   // Advance to the next sampled pwm_period_end pulse, bounded.
   task automatic wait_pe(input string tag);
      int n    = 0;
      bit seen = 1'b0;
      while (!seen && n < 4000) begin
         @(negedge clk);
         n++;
         seen = (pwm_period_end === 1'b1);
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s: no pwm_period_end within %0d cycles", tag, n);
      end
   endtask

   task automatic push_exp(input string tag, input int highs, input int len,
                           input int rises, input int duty);
      exp_t e;
      e.tag   = tag;
      e.highs = highs;
      e.len   = len;
      e.rises = rises;
      e.duty  = duty;
      sb_q.push_back(e);
   endtask

   // Called on the sampled period_end cycle; observes the following period up to
   // and including its period_end cycle, then checks it against the scoreboard.
   task automatic measure_period();
      exp_t e;
      int   highs = 0;
      int   len   = 0;
      int   rises = 0;
      int   duty;
      logic prev;
      bit   done  = 1'b0;
      duty = int'(duty_cur);
      prev = pwm_out;
      while (!done && len < 5000) begin
         @(negedge clk);
         len++;
         if (pwm_out === 1'b1) highs++;
         if (pwm_out === 1'b1 && prev === 1'b0) rises++;
         prev = pwm_out;
         done = (pwm_period_end === 1'b1);
      end
      total++;
      if (sb_q.size() == 0) begin
         bad++;
         $display("FAIL scoreboard: no expectation queued for measured period");
      end else begin
         e = sb_q.pop_front();
         if (len !== e.len) begin
            bad++;
            $display("FAIL %s len: got %0d expected %0d", e.tag, len, e.len);
         end
         total++;
         if (highs !== e.highs) begin
            bad++;
            $display("FAIL %s highs: got %0d expected %0d", e.tag, highs, e.highs);
         end
         total++;
         if (rises !== e.rises) begin
            bad++;
            $display("FAIL %s rises: got %0d expected %0d", e.tag, rises, e.rises);
         end
         total++;
         if (duty !== e.duty) begin
            bad++;
            $display("FAIL %s duty_cur: got %0d expected %0d", e.tag, duty, e.duty);
         end
      end
   endtask

   task automatic test_reset();
      reset_n    = 1'b1;
      pwm_ena    = 1'b0;
      pwm_inv    = 1'b0;
      pwm_mode   = 1'b0;
      pwm_div    = '0;
      pwm_val    = '0;
      pwm_val_up = 1'b0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (pwm_out !== 1'b0) begin
         bad++;
         $display("FAIL reset pwm_out: got %b expected 0", pwm_out);
      end
      total++;
      if (pwm_period_end !== 1'b0) begin
         bad++;
         $display("FAIL reset pwm_period_end: got %b expected 0", pwm_period_end);
      end
      total++;
      if (duty_cur !== 8'd0) begin
         bad++;
         $display("FAIL reset duty_cur: got %0d expected 0", duty_cur);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_counter();
      @(negedge clk);
      pwm_div  = 4'd0;
      pwm_mode = 1'b0;
      pwm_inv  = 1'b0;
      pwm_ena  = 1'b1;
      strobe(8'd64);
      wait_pe("counter load");
      total++;
      if (duty_cur !== 8'd64) begin
         bad++;
         $display("FAIL counter duty_cur: got %0d expected 64", duty_cur);
      end
      push_exp("counter duty 64", 64, 256, 1, 64);
      measure_period();
   endtask

   task automatic test_double_buffer();
      bit held = 1'b1;
      strobe(8'd100);
      wait_pe("db load 100");
      total++;
      if (duty_cur !== 8'd100) begin
         bad++;
         $display("FAIL db initial duty_cur: got %0d expected 100", duty_cur);
      end
      for (int i = 1; i <= 255; i++) begin
         @(negedge clk);
         if (duty_cur !== 8'd100) held = 1'b0;
         pwm_val    = (i < 100) ? 8'd64 : 8'd200;
         pwm_val_up = (i == 20) || (i == 100);
      end
      total++;
      if (!held) begin
         bad++;
         $display("FAIL db hold: duty_cur left 100 mid-period (now %0d)", duty_cur);
      end
      @(negedge clk);
      total++;
      if (pwm_period_end !== 1'b1) begin
         bad++;
         $display("FAIL db boundary: pwm_period_end got %b expected 1", pwm_period_end);
      end
      total++;
      if (duty_cur !== 8'd200) begin
         bad++;
         $display("FAIL db newest wins: duty_cur got %0d expected 200", duty_cur);
      end
      push_exp("db duty 200", 200, 256, 1, 200);
      measure_period();
   endtask

   task automatic test_simultaneous();
      for (int i = 1; i <= 255; i++) begin
         @(negedge clk);
         pwm_val    = 8'd64;
         pwm_val_up = (i == 10);
      end
      pwm_val    = 8'd128;
      pwm_val_up = 1'b1;
      @(negedge clk);
      pwm_val_up = 1'b0;
      total++;
      if (pwm_period_end !== 1'b1) begin
         bad++;
         $display("FAIL sim boundary: pwm_period_end got %b expected 1", pwm_period_end);
      end
      total++;
      if (duty_cur !== 8'd128) begin
         bad++;
         $display("FAIL sim direct load: duty_cur got %0d expected 128", duty_cur);
      end
      wait_pe("sim next boundary");
      push_exp("sim duty 128 kept", 128, 256, 1, 128);
      measure_period();
   endtask

   task automatic test_sigma_delta();
      @(negedge clk);
      pwm_div  = 4'd3;
      pwm_mode = 1'b1;
      strobe(8'd1);
      wait_pe("sd enter");
      wait_pe("sd settle 1");
      push_exp("sd duty 1", 4, 1024, 1, 1);
      measure_period();
      strobe(8'd128);
      wait_pe("sd load 128");
      wait_pe("sd settle 128");
      push_exp("sd duty 128", 512, 1024, 128, 128);
      measure_period();
   endtask

   task automatic test_edges();
      @(negedge clk);
      pwm_div  = 4'd0;
      pwm_mode = 1'b0;
      strobe(8'd0);
      wait_pe("edge load 0");
      push_exp("counter duty 0", 0, 256, 0, 0);
      measure_period();
      pwm_inv = 1'b1;
      @(negedge clk);
      total++;
      if (pwm_out !== 1'b1) begin
         bad++;
         $display("FAIL inv next clk: pwm_out got %b expected 1", pwm_out);
      end
      wait_pe("edge inv");
      push_exp("inv duty 0", 256, 256, 0, 0);
      measure_period();
      pwm_inv = 1'b0;
   endtask

   task automatic test_disable();
      bit quiet = 1'b1;
      int n     = 0;
      bit seen  = 1'b0;
      strobe(8'd64);
      wait_pe("dis load 64");
      @(negedge clk);
      total++;
      if (pwm_out !== 1'b1) begin
         bad++;
         $display("FAIL dis pre: pwm_out got %b expected 1", pwm_out);
      end
      pwm_ena = 1'b0;
      @(negedge clk);
      total++;
      if (pwm_out !== 1'b0) begin
         bad++;
         $display("FAIL dis park: pwm_out got %b expected 0", pwm_out);
      end
      pwm_inv = 1'b1;
      @(negedge clk);
      total++;
      if (pwm_out !== 1'b1) begin
         bad++;
         $display("FAIL dis inv: pwm_out got %b expected 1", pwm_out);
      end
      pwm_val = 8'd77;
      @(negedge clk);
      total++;
      if (duty_cur !== 8'd77) begin
         bad++;
         $display("FAIL dis follow: duty_cur got %0d expected 77", duty_cur);
      end
      repeat (600) begin
         @(negedge clk);
         if (pwm_period_end !== 1'b0) quiet = 1'b0;
      end
      total++;
      if (!quiet) begin
         bad++;
         $display("FAIL dis quiet: pwm_period_end pulsed while disabled");
      end
      pwm_inv = 1'b0;
      pwm_div = 4'd1;
      pwm_ena = 1'b1;
      while (!seen && n < 4000) begin
         @(negedge clk);
         n++;
         seen = (pwm_period_end === 1'b1);
      end
      total++;
      if (!seen || n !== 512) begin
         bad++;
         $display("FAIL reenable first period_end: got %0d cycles (seen=%0b) expected 512", n, seen);
      end
   endtask

   task automatic test_reset_mid();
      int n    = 0;
      bit seen = 1'b0;
      @(negedge clk);
      pwm_div = 4'd0;
      strobe(8'd200);
      wait_pe("rst load 200");
      repeat (20) @(negedge clk);
      total++;
      if (pwm_out !== 1'b1 || duty_cur !== 8'd200) begin
         bad++;
         $display("FAIL rst pre: pwm_out=%b duty_cur=%0d expected 1/200", pwm_out, duty_cur);
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (pwm_out !== 1'b0) begin
         bad++;
         $display("FAIL rst async pwm_out: got %b expected 0", pwm_out);
      end
      total++;
      if (duty_cur !== 8'd0) begin
         bad++;
         $display("FAIL rst async duty_cur: got %0d expected 0", duty_cur);
      end
      total++;
      if (pwm_period_end !== 1'b0) begin
         bad++;
         $display("FAIL rst async pwm_period_end: got %b expected 0", pwm_period_end);
      end
      @(negedge clk);
      reset_n = 1'b1;
      while (!seen && n < 4000) begin
         @(negedge clk);
         n++;
         seen = (pwm_period_end === 1'b1);
      end
      total++;
      if (!seen || n !== 256) begin
         bad++;
         $display("FAIL rst restart phase: first period_end after %0d cycles (seen=%0b) expected 256", n, seen);
      end
   endtask

   initial begin
      test_reset();
      test_counter();
      test_double_buffer();
      test_simultaneous();
      test_sigma_delta();
      test_edges();
      test_disable();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_agc_pwm_mod
